// File: rtl/bulk_pkg.sv
// Shared sizing and state/type definitions for the bulk RX register bank.
// Pure declarations; no latency or backpressure of its own.
package bulk_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int RAM_DEPTH  = 256;
  localparam int ADDR_W     = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} bank_state_t;

  // Where the held read result comes from.
  typedef enum logic [1:0] {RD_ZERO, RD_RAM, RD_BYP} rd_src_t;
endpackage

// File: rtl/bulk_ram.sv
// Simple dual-port storage: one write port, one synchronous read port, no reset.
// Read data appears one cycle after re; old data on same-address collision.
// No backpressure: every write and read enable is taken.
module bulk_ram
  import bulk_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bulk_rx_regbank.sv
// Register bank sink for UART bulk writes, with clear sweep, stats and link-loss flag (BULK_RX_TIMEOUT_EN).
// Read data valid one cycle after rd_en; upd/last_addr/wr_count update the cycle after a write.
// wr_ready is low for the whole INIT/CLEAR sweep and high in IDLE only.
module bulk_rx_regbank
  import bulk_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd10_000_000
)
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  upd,
  output logic [ADDR_W-1:0]     last_addr,
  output logic [15:0]           wr_count,
  output logic                  stale
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(RAM_DEPTH - 1);

  bank_state_t           state;
  logic [ADDR_W-1:0]     sweep_ptr;
  logic                  sweeping;
  logic                  accept;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  rd_src_t               rd_src;
  logic [DATA_WIDTH-1:0] byp_data;

  assign sweeping  = (state != IDLE);
  assign accept    = wr_valid && wr_ready;
  // The sweep owns the write port; host writes can only land in IDLE.
  assign ram_we    = sweeping || accept;
  assign ram_waddr = sweeping ? sweep_ptr : wr_addr;
  assign ram_wdata = sweeping ? '0 : wr_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= INIT;
      sweep_ptr <= '0;
      wr_ready  <= 1'b0;
    end else begin
      unique case (state)
        INIT, CLEAR: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (sweep_ptr == PTR_LAST) begin
            state     <= IDLE;
            sweep_ptr <= '0;
            wr_ready  <= 1'b1;
          end
        end
        IDLE: begin
          if (clr) begin
            state    <= CLEAR;
            wr_ready <= 1'b0;
          end
        end
        default: begin
          state     <= INIT;
          sweep_ptr <= '0;
          wr_ready  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      upd       <= 1'b0;
      last_addr <= '0;
      wr_count  <= '0;
    end else begin
      upd <= accept;
      if (accept) last_addr <= wr_addr;
      // A write in the clr cycle still lands, but the count restarts with the sweep.
      if (state == IDLE && clr)
        wr_count <= '0;
      else if (accept && wr_count != 16'hFFFF)
        wr_count <= wr_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_src   <= RD_ZERO;
      byp_data <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (sweeping) begin
          rd_src <= RD_ZERO;
        end else if (accept && wr_addr == rd_addr) begin
          rd_src   <= RD_BYP;
          byp_data <= wr_data;
        end else begin
          rd_src <= RD_RAM;
        end
      end
    end
  end

  // RAM output has no reset, so the source select keeps rd_data at zero out of reset.
  always_comb begin
    rd_data = '0;
    case (rd_src)
      RD_RAM:  rd_data = ram_rdata;
      RD_BYP:  rd_data = byp_data;
      default: rd_data = '0;
    endcase
  end

  bulk_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

`ifdef BULK_RX_TIMEOUT_EN
  localparam logic [31:0] STALE_AT = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] idle_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
      stale    <= 1'b1;
    end else if (accept) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else begin
      if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt >= STALE_AT) stale <= 1'b1;
    end
  end
`else
  assign stale = 1'b0;
`endif

endmodule
